// File: rtl/usb_xfer_ctrl.sv
// USB full-speed device endpoint transaction controller: decodes receiver packet ends,
// chooses the ACK/NAK/DATAx response, sequences the transmitter and tracks data toggle.
module usb_xfer_ctrl #(
    parameter int unsigned TIMEOUT = 144
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] rx_packet,
    input  logic       rx_transfer_active,
    input  logic       rx_error,
    input  logic [6:0] buffer_occupancy,
    input  logic       host_data_ready,
    input  logic       host_rx_ack,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [1:0] tx_packet,
    output logic       d_mode,
    output logic       rx_data_ready,
    output logic       tx_complete,
    output logic       proto_error,
    output logic       flush
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_OUT_DATA  = 3'd1;
    localparam logic [2:0] S_SEND_ACK  = 3'd2;
    localparam logic [2:0] S_SEND_NAK  = 3'd3;
    localparam logic [2:0] S_SEND_DATA = 3'd4;
    localparam logic [2:0] S_WAIT_HS   = 3'd5;
    localparam logic [2:0] S_ERR       = 3'd6;

    localparam logic [2:0] RX_OUT = 3'd0;
    localparam logic [2:0] RX_IN  = 3'd1;
    localparam logic [2:0] RX_ACK = 3'd2;

    localparam logic [1:0] TX_ACK = 2'd2;
    localparam logic [1:0] TX_NAK = 2'd3;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          rx_active_q;
    logic          toggle_q, toggle_d;
    logic          out_pending_q;
    logic          out_set;
    logic          enter_q, enter_d;
    logic          tx_start_q;
    logic [1:0]    tx_packet_q;
    logic          d_mode_q;
    logic          tx_complete_q, tx_complete_d;
    logic          proto_error_q, proto_error_d;
    logic          flush_q, flush_d;

    logic pkt_end, pkt_good, timeout, counting, in_send_q, in_send_d;

    assign pkt_end   = rx_active_q & ~rx_transfer_active;
    assign pkt_good  = pkt_end & ~rx_error;
    assign counting  = (state_q == S_OUT_DATA) || (state_q == S_WAIT_HS);
    // Compare one short so the ERR pulses appear exactly TIMEOUT cycles after entry.
    assign timeout   = counting && (cnt_q == CW'(TIMEOUT - 1));
    assign in_send_q = (state_q == S_SEND_ACK) || (state_q == S_SEND_NAK) || (state_q == S_SEND_DATA);
    assign in_send_d = (state_d == S_SEND_ACK) || (state_d == S_SEND_NAK) || (state_d == S_SEND_DATA);
    assign enter_d   = in_send_d && (state_d != state_q);

    always_comb begin
        state_d       = state_q;
        toggle_d      = toggle_q;
        out_set       = 1'b0;
        flush_d       = 1'b0;
        proto_error_d = 1'b0;
        tx_complete_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_good && rx_packet == RX_OUT) begin
                    state_d = S_OUT_DATA;
                end else if (pkt_good && rx_packet == RX_IN) begin
                    state_d = (host_data_ready && buffer_occupancy != '0) ? S_SEND_DATA : S_SEND_NAK;
                end
            end
            S_OUT_DATA: begin
                if (pkt_end) begin
                    if (rx_error) begin
                        state_d       = S_ERR;
                        proto_error_d = 1'b1;
                        flush_d       = 1'b1;
                    end else if (out_pending_q) begin
                        state_d = S_SEND_NAK;
                        flush_d = 1'b1;
                    end else begin
                        state_d = S_SEND_ACK;
                        out_set = 1'b1;
                    end
                end else if (timeout) begin
                    state_d       = S_ERR;
                    proto_error_d = 1'b1;
                    flush_d       = 1'b1;
                end
            end
            S_SEND_ACK, S_SEND_NAK, S_SEND_DATA: begin
                if (tx_done && d_mode_q) begin
                    state_d = (state_q == S_SEND_DATA) ? S_WAIT_HS : S_IDLE;
                end
            end
            S_WAIT_HS: begin
                if (pkt_end) begin
                    if (!rx_error && rx_packet == RX_ACK) begin
                        toggle_d      = ~toggle_q;
                        tx_complete_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (timeout) begin
                    state_d       = S_ERR;
                    proto_error_d = 1'b1;
                    flush_d       = 1'b1;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rx_active_q   <= 1'b0;
            toggle_q      <= 1'b0;
            out_pending_q <= 1'b0;
            enter_q       <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_packet_q   <= TX_NAK;
            d_mode_q      <= 1'b0;
            tx_complete_q <= 1'b0;
            proto_error_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_active_q   <= rx_transfer_active;
            toggle_q      <= toggle_d;
            enter_q       <= enter_d;
            tx_start_q    <= enter_q;
            tx_complete_q <= tx_complete_d;
            proto_error_q <= proto_error_d;
            flush_q       <= flush_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (counting) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (out_set) begin
                out_pending_q <= 1'b1;
            end else if (host_rx_ack) begin
                out_pending_q <= 1'b0;
            end

            // Packet code is latched with tx_start and held until the next send.
            if (enter_q && in_send_q) begin
                case (state_q)
                    S_SEND_ACK: tx_packet_q <= TX_ACK;
                    S_SEND_NAK: tx_packet_q <= TX_NAK;
                    default:    tx_packet_q <= {1'b0, toggle_q};
                endcase
            end

            if (enter_q) begin
                d_mode_q <= 1'b1;
            end else if (tx_done) begin
                d_mode_q <= 1'b0;
            end
        end
    end

    assign tx_start      = tx_start_q;
    assign tx_packet     = tx_packet_q;
    assign d_mode        = d_mode_q;
    assign rx_data_ready = out_pending_q;
    assign tx_complete   = tx_complete_q;
    assign proto_error   = proto_error_q;
    assign flush         = flush_q;

endmodule

// File: tb/tb_usb_xfer_ctrl.sv
// Bench for usb_xfer_ctrl: transaction table plus hand-timed sequences, with an event
// scoreboard fed when stimulus is driven and drained by a negedge output monitor.
module tb_usb_xfer_ctrl;

    localparam int TO = 16;

    localparam int K_OUT   = 0;
    localparam int K_IN    = 1;
    localparam int K_DRAIN = 2;
    localparam int K_TOK   = 3;

    // Output event codes: 0..3 tx_start with that tx_packet, then the pulse kinds.
    localparam int EV_TXC   = 4;
    localparam int EV_FLUSH = 5;
    localparam int EV_ERR   = 6;
    localparam int EV_PERR  = 7;

    logic       clk;
    logic       n_rst;
    logic [2:0] rx_packet;
    logic       rx_transfer_active;
    logic       rx_error;
    logic [6:0] buffer_occupancy;
    logic       host_data_ready;
    logic       host_rx_ack;
    logic       tx_done;
    logic       tx_start;
    logic [1:0] tx_packet;
    logic       d_mode;
    logic       rx_data_ready;
    logic       tx_complete;
    logic       proto_error;
    logic       flush;

    usb_xfer_ctrl #(.TIMEOUT(TO)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .rx_packet          (rx_packet),
        .rx_transfer_active (rx_transfer_active),
        .rx_error           (rx_error),
        .buffer_occupancy   (buffer_occupancy),
        .host_data_ready    (host_data_ready),
        .host_rx_ack        (host_rx_ack),
        .tx_done            (tx_done),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .d_mode             (d_mode),
        .rx_data_ready      (rx_data_ready),
        .tx_complete        (tx_complete),
        .proto_error        (proto_error),
        .flush              (flush)
    );

    typedef struct {
        int         kind;
        bit         hdr;
        logic [6:0] occ;
        bit         hs_en;
        logic [2:0] hs;
        bit         err;
        int         ev0;
        int         ev1;
        bit         rdr;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int exp_q[$];
    logic [1:0] tx_held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic sb_check(input string name, input int got);
        int e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event %0d, expected none (t=%0t)", name, got, $time);
        end else begin
            e = exp_q.pop_front();
            if (e != got) begin
                n_bad++;
                $display("FAIL %s: event %0d expected %0d (t=%0t)", name, got, e, $time);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Receiver model: a packet whose end is reported with the given code and error flag.
    task automatic pkt(input logic [2:0] code, input bit err);
        cyc(1);
        rx_packet          = code;
        rx_transfer_active = 1'b1;
        cyc(3);
        rx_transfer_active = 1'b0;
        rx_error           = err;
        cyc(1);
        rx_error  = 1'b0;
        rx_packet = 3'b100;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_packet", tx_packet, 3);
        chk("rst_d_mode", d_mode, 0);
        chk("rst_rx_data_ready", rx_data_ready, 0);
        chk("rst_tx_complete", tx_complete, 0);
        chk("rst_proto_error", proto_error, 0);
        chk("rst_flush", flush, 0);
    endtask

    function automatic vec_t mk(int kind, bit hdr, int occ, bit hs_en, logic [2:0] hs,
                                bit err, int ev0, int ev1, bit rdr);
        vec_t v;
        v.kind = kind; v.hdr = hdr; v.occ = 7'(occ); v.hs_en = hs_en; v.hs = hs;
        v.err = err; v.ev0 = ev0; v.ev1 = ev1; v.rdr = rdr;
        return v;
    endfunction

    task automatic apply_row(input vec_t v);
        if (v.ev0 >= 0) exp_q.push_back(v.ev0);
        if (v.ev1 >= 0) exp_q.push_back(v.ev1);
        case (v.kind)
            K_OUT: begin
                buffer_occupancy = v.occ;
                pkt(3'd0, 1'b0);
                pkt(3'b100, v.err);
            end
            K_IN: begin
                host_data_ready  = v.hdr;
                buffer_occupancy = v.occ;
                pkt(3'd1, 1'b0);
                if (v.hs_en) begin
                    cyc(8);
                    pkt(v.hs, v.err);
                end
            end
            K_DRAIN: begin
                cyc(1);
                host_rx_ack = 1'b1;
                cyc(1);
                host_rx_ack = 1'b0;
            end
            default: pkt(v.hs, v.err);
        endcase
        cyc(30);
        chk("rx_data_ready", rx_data_ready, v.rdr);
    endtask

    // Output monitor draining the scoreboard.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (tx_start) sb_check("tx_start", int'(tx_packet));
            if (flush || proto_error)
                sb_check("flush_proto_error", proto_error ? (flush ? EV_ERR : EV_PERR) : EV_FLUSH);
            if (tx_complete) sb_check("tx_complete", EV_TXC);
        end
    end

    // Transmitter model: finishes each packet 4 cycles after tx_start.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && tx_start === 1'b1) begin
            tx_held = tx_packet;
            chk("d_mode_at_start", d_mode, 1);
            repeat (4) @(posedge clk);
            #1;
            chk("tx_packet_held", tx_packet, tx_held);
            chk("d_mode_busy", d_mode, 1);
            tx_done = 1'b1;
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            chk("d_mode_release", d_mode, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[20];
        int   n;
        bit   s0, s1, s2;

        tbl[0]  = mk(K_OUT,   0,  8, 0, 3'd0,   0, 2,        -1,     1);
        tbl[1]  = mk(K_OUT,   0,  8, 0, 3'd0,   0, EV_FLUSH, 3,      1);
        tbl[2]  = mk(K_DRAIN, 0,  0, 0, 3'd0,   0, -1,       -1,     0);
        tbl[3]  = mk(K_IN,    1,  4, 1, 3'd2,   0, 0,        EV_TXC, 0);
        tbl[4]  = mk(K_IN,    1,  4, 1, 3'd2,   0, 1,        EV_TXC, 0);
        tbl[5]  = mk(K_IN,    1,  4, 1, 3'd3,   0, 0,        -1,     0);
        tbl[6]  = mk(K_IN,    1,  4, 1, 3'd2,   0, 0,        EV_TXC, 0);
        tbl[7]  = mk(K_IN,    0,  4, 0, 3'd0,   0, 3,        -1,     0);
        tbl[8]  = mk(K_IN,    1,  0, 0, 3'd0,   0, 3,        -1,     0);
        tbl[9]  = mk(K_IN,    1, 64, 1, 3'd2,   0, 1,        EV_TXC, 0);
        tbl[10] = mk(K_OUT,   0,  8, 0, 3'd0,   1, EV_ERR,   -1,     0);
        tbl[11] = mk(K_IN,    1,  1, 1, 3'd2,   1, 0,        -1,     0);
        tbl[12] = mk(K_IN,    1,  1, 0, 3'd0,   0, 0,        EV_ERR, 0);
        tbl[13] = mk(K_IN,    1,  1, 1, 3'b100, 0, 0,        -1,     0);
        tbl[14] = mk(K_IN,    1,  1, 1, 3'd2,   0, 0,        EV_TXC, 0);
        tbl[15] = mk(K_TOK,   0,  0, 1, 3'd2,   0, -1,       -1,     0);
        tbl[16] = mk(K_OUT,   0, 16, 0, 3'd0,   0, 2,        -1,     1);
        tbl[17] = mk(K_OUT,   0, 16, 0, 3'd0,   1, EV_ERR,   -1,     1);
        tbl[18] = mk(K_DRAIN, 0,  0, 0, 3'd0,   0, -1,       -1,     0);
        tbl[19] = mk(K_IN,    1,  2, 1, 3'd2,   0, 1,        EV_TXC, 0);

        n_rst = 1'b0;
        rx_packet = 3'b100;
        rx_transfer_active = 1'b0;
        rx_error = 1'b0;
        buffer_occupancy = '0;
        host_data_ready = 1'b0;
        host_rx_ack = 1'b0;
        tx_done = 1'b0;
        cyc(3);
        chk_reset_outputs();
        n_rst = 1'b1;
        cyc(3);

        for (int i = 0; i < 20; i++) apply_row(tbl[i]);

        // tx_start lands two cycles after rx_transfer_active falls.
        host_data_ready = 1'b0;
        exp_q.push_back(3);
        cyc(1);
        rx_packet = 3'd1;
        rx_transfer_active = 1'b1;
        cyc(3);
        rx_transfer_active = 1'b0;
        @(negedge clk); s0 = tx_start;
        @(negedge clk); s1 = tx_start;
        @(negedge clk); s2 = tx_start;
        rx_packet = 3'b100;
        chk("tx_start_latency", int'({s0, s1, s2}), 1);
        cyc(20);

        // OUT token then silence: error pulses exactly TO cycles after OUT_DATA entry.
        exp_q.push_back(EV_ERR);
        pkt(3'd0, 1'b0);
        n = 0;
        for (int i = 0; i < TO + 10; i++) begin
            @(negedge clk);
            n++;
            if (proto_error) break;
        end
        chk("timeout_latency", n, TO + 1);
        chk("timeout_flush", flush, 1);
        cyc(10);
        chk("timeout_rx_data_ready", rx_data_ready, 0);

        // Reset during WAIT_HS with toggle at 1, then the next IN must send DATA0.
        apply_row(mk(K_IN, 1, 4, 1, 3'd2, 0, 0, EV_TXC, 0));
        exp_q.push_back(1);
        host_data_ready = 1'b1;
        pkt(3'd1, 1'b0);
        cyc(10);
        n_rst = 1'b0;
        #1;
        chk_reset_outputs();
        cyc(2);
        n_rst = 1'b1;
        cyc(2);
        apply_row(mk(K_IN, 1, 4, 1, 3'd2, 0, 0, EV_TXC, 0));

        cyc(10);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
